// File: rtl/kfx86_muldiv_unit_pkg.sv
// Shared types for the multiply/divide unit: processor flags and opcode encoding.
package kfx86_muldiv_unit_pkg;

  typedef struct packed {
    logic o;
    logic d;
    logic i;
    logic t;
    logic s;
    logic z;
    logic a;
    logic p;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_IMUL = 2'b01,
    MD_DIV  = 2'b10,
    MD_IDIV = 2'b11
  } md_op_e;

  localparam logic [3:0] LAST_STEP_BYTE = 4'd7;
  localparam logic [3:0] LAST_STEP_WORD = 4'd15;

  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/kfx86_muldiv_step.sv
// One iteration of the sequential engine: add-then-shift-right for multiply,
// compare/subtract-then-shift-left for restoring divide.
module kfx86_muldiv_step (
  input  logic        is_div_i,
  input  logic        word_i,
  input  logic [16:0] acc_i,
  input  logic [15:0] sr_i,
  input  logic [15:0] m_i,
  output logic [16:0] acc_o,
  output logic [15:0] sr_o
);

  logic [16:0] sum;
  logic [16:0] shl;
  logic [16:0] diff;
  logic        ge;
  logic        msb_out;

  // Single combinational step; byte mode keeps the shift register in [7:0]
  always_comb begin
    sum     = acc_i + {1'b0, m_i};
    msb_out = word_i ? sr_i[15] : sr_i[7];
    shl     = {acc_i[15:0], msb_out};
    diff    = shl - {1'b0, m_i};
    ge      = (shl >= {1'b0, m_i});
    acc_o   = '0;
    sr_o    = '0;
    if (is_div_i) begin
      acc_o = ge ? diff : shl;
      sr_o  = word_i ? {sr_i[14:0], ge} : {8'h00, sr_i[6:0], ge};
    end else begin
      if (sr_i[0]) begin
        acc_o = {1'b0, sum[16:1]};
        sr_o  = word_i ? {sum[0], sr_i[15:1]} : {8'h00, sum[0], sr_i[7:1]};
      end else begin
        acc_o = {1'b0, acc_i[16:1]};
        sr_o  = word_i ? {acc_i[0], sr_i[15:1]} : {8'h00, acc_i[0], sr_i[7:1]};
      end
    end
  end

endmodule

// File: rtl/kfx86_muldiv_unit.sv
// Sequential MUL/IMUL/DIV/IDIV engine, one bit per cycle on operand magnitudes,
// signs applied at the end.
module kfx86_muldiv_unit
  import kfx86_muldiv_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear,
  input  logic [1:0]  opcode,
  input  logic        select_word,
  input  logic [15:0] source_high,
  input  logic [15:0] source_low,
  input  logic [15:0] source_2,
  input  flags_t      source_flags,
  output logic        busy,
  output logic        done,
  output logic        divide_error,
  output logic [15:0] out_high,
  output logic [15:0] out_low,
  output flags_t      out_flags
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

  state_e      state_q;
  md_op_e      op_q;
  logic        word_q;
  logic [15:0] hi_q, lo_q, s2_q;
  flags_t      flags_in_q;
  logic [16:0] acc_q;
  logic [15:0] sr_q, m_q;
  logic [3:0]  cnt_q;
  logic        qneg_q, rneg_q, ovf_q;
  logic        done_q, divide_error_q;
  logic [15:0] out_high_q, out_low_q;
  flags_t      out_flags_q;

  logic        is_div, signed_op, a_sign, b_sign, prep_err, prep_ovf;
  logic [15:0] b_ext, b_mag, mul_ext, mul_mag, dvd_hi, dvd_lo;
  logic [31:0] dvd_mag;
  logic [16:0] step_acc;
  logic [15:0] step_sr;
  logic [31:0] prod_s;
  logic [15:0] upper, sext, q, r, qs, rs, fix_high, fix_low;
  logic        co, fix_err;
  flags_t      fix_flags;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign divide_error = divide_error_q;
  assign out_high     = out_high_q;
  assign out_low      = out_low_q;
  assign out_flags    = out_flags_q;

  // Operand magnitudes and early divide checks, used in PREP
  always_comb begin
    is_div    = (op_q == MD_DIV) || (op_q == MD_IDIV);
    signed_op = (op_q == MD_IMUL) || (op_q == MD_IDIV);
    b_sign    = word_q ? s2_q[15] : s2_q[7];
    b_ext     = word_q ? s2_q : {{8{signed_op & s2_q[7]}}, s2_q[7:0]};
    b_mag     = (signed_op && b_sign) ? (~b_ext + 16'd1) : b_ext;
    if (is_div) a_sign = word_q ? hi_q[15] : lo_q[15];
    else        a_sign = word_q ? lo_q[15] : lo_q[7];
    mul_ext   = word_q ? lo_q : {{8{signed_op & lo_q[7]}}, lo_q[7:0]};
    mul_mag   = (signed_op && a_sign) ? (~mul_ext + 16'd1) : mul_ext;
    dvd_mag   = cond_neg32(signed_op && a_sign,
                           word_q ? {hi_q, lo_q} : {{16{signed_op & lo_q[15]}}, lo_q});
    dvd_hi    = word_q ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    dvd_lo    = word_q ? dvd_mag[15:0]  : {8'h00, dvd_mag[7:0]};
    prep_err  = is_div && ((b_mag == 16'd0) || ((op_q == MD_DIV) && (dvd_hi >= b_mag)));
    prep_ovf  = (op_q == MD_IDIV) && (dvd_hi >= b_mag);
  end

  kfx86_muldiv_step u_step (
    .is_div_i (is_div),
    .word_i   (word_q),
    .acc_i    (acc_q),
    .sr_i     (sr_q),
    .m_i      (m_q),
    .acc_o    (step_acc),
    .sr_o     (step_sr)
  );

  // Sign fix-up, result mapping, flags and IDIV range check, used in FIX
  always_comb begin
    prod_s = cond_neg32(qneg_q, word_q ? {acc_q[15:0], sr_q} : {16'h0000, acc_q[7:0], sr_q[7:0]});
    upper  = word_q ? prod_s[31:16] : {8'h00, prod_s[15:8]};
    sext   = word_q ? {16{prod_s[15]}} : {8'h00, {8{prod_s[7]}}};
    co     = (op_q == MD_IMUL) ? (upper != sext) : (upper != 16'h0000);
    q      = word_q ? sr_q : {8'h00, sr_q[7:0]};
    r      = word_q ? acc_q[15:0] : {8'h00, acc_q[7:0]};
    qs     = qneg_q ? (~q + 16'd1) : q;
    rs     = rneg_q ? (~r + 16'd1) : r;
    fix_flags = flags_in_q;
    if (is_div) begin
      fix_high = word_q ? rs : 16'h0000;
      fix_low  = word_q ? qs : {rs[7:0], qs[7:0]};
      // Magnitude >= 2^(N-1) rejects -0x80/-0x8000 too, matching the 8086
      fix_err  = (op_q == MD_IDIV) && (ovf_q || (word_q ? q[15] : q[7]));
    end else begin
      fix_high    = word_q ? prod_s[31:16] : 16'h0000;
      fix_low     = prod_s[15:0];
      fix_err     = 1'b0;
      fix_flags.c = co;
      fix_flags.o = co;
    end
  end

  // Control FSM with registered outputs and iteration datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      op_q           <= MD_MUL;
      word_q         <= 1'b0;
      hi_q           <= '0;
      lo_q           <= '0;
      s2_q           <= '0;
      flags_in_q     <= '0;
      acc_q          <= '0;
      sr_q           <= '0;
      m_q            <= '0;
      cnt_q          <= '0;
      qneg_q         <= 1'b0;
      rneg_q         <= 1'b0;
      ovf_q          <= 1'b0;
      done_q         <= 1'b0;
      divide_error_q <= 1'b0;
      out_high_q     <= '0;
      out_low_q      <= '0;
      out_flags_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            op_q       <= md_op_e'(opcode);
            word_q     <= select_word;
            hi_q       <= source_high;
            lo_q       <= source_low;
            s2_q       <= source_2;
            flags_in_q <= source_flags;
            state_q    <= PREP;
          end
          PREP: begin
            acc_q  <= is_div ? {1'b0, dvd_hi} : '0;
            sr_q   <= is_div ? dvd_lo : b_mag;
            m_q    <= is_div ? b_mag : mul_mag;
            cnt_q  <= '0;
            qneg_q <= signed_op & (a_sign ^ b_sign);
            rneg_q <= signed_op & a_sign;
            ovf_q  <= prep_ovf;
            if (prep_err) begin
              done_q         <= 1'b1;
              divide_error_q <= 1'b1;
              state_q        <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
          CALC: begin
            acc_q <= step_acc;
            sr_q  <= step_sr;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == (word_q ? LAST_STEP_WORD : LAST_STEP_BYTE)) state_q <= FIX;
          end
          FIX: begin
            if (!fix_err) begin
              out_high_q  <= fix_high;
              out_low_q   <= fix_low;
              out_flags_q <= fix_flags;
            end
            done_q         <= 1'b1;
            divide_error_q <= fix_err;
            state_q        <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kfx86_muldiv_unit.sv
// Directed bench for kfx86_muldiv_unit: vector table plus control-abuse sequences.
module tb_kfx86_muldiv_unit;
  import kfx86_muldiv_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic        select_word = 1'b0;
  logic [15:0] source_high = '0, source_low = '0, source_2 = '0;
  flags_t      source_flags = '0;
  logic        busy, done, divide_error;
  logic [15:0] out_high, out_low;
  flags_t      out_flags;

  int total = 0;
  int bad = 0;

  kfx86_muldiv_unit dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .clear        (clear),
    .opcode       (opcode),
    .select_word  (select_word),
    .source_high  (source_high),
    .source_low   (source_low),
    .source_2     (source_2),
    .source_flags (source_flags),
    .busy         (busy),
    .done         (done),
    .divide_error (divide_error),
    .out_high     (out_high),
    .out_low      (out_low),
    .out_flags    (out_flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [15:0] hi, lo, s2;
    logic [8:0]  fl;
    logic        err;
    logic [15:0] eh, el;
    logic        co;
    int          lat;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Launch one operation; lat = edge (start edge = 0) at which done is sampled, -1 on timeout
  task automatic run_op(input logic [1:0] op, input logic w, input logic [15:0] hi,
                        input logic [15:0] lo, input logic [15:0] s2, input logic [8:0] fl,
                        output int lat, output logic err);
    int cyc;
    opcode = op; select_word = w; source_high = hi; source_low = lo; source_2 = s2;
    source_flags = flags_t'(fl);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clock); #1;
      cyc++;
    end
    lat = (done === 1'b1) ? cyc + 1 : -1;
    err = divide_error;
    @(posedge clock); #1;
  endtask

  logic [15:0] k_high = '0, k_low = '0;
  flags_t      k_flags = '0;
  flags_t      ef;
  int          lat, cnt;
  logic        err;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    //           op       w     hi       lo       s2       fl      err   eh       el       co    lat
    vecs[0]  = '{MD_DIV,  1'b1, 16'h0001,16'h0000,16'h0003,9'h0D5, 1'b0, 16'h0001,16'h5555,1'b0, 19};
    vecs[1]  = '{MD_DIV,  1'b0, 16'h0000,16'h1234,16'h0000,9'h1FF, 1'b1, 16'h0000,16'h0000,1'b0, 2};
    vecs[2]  = '{MD_IDIV, 1'b0, 16'h0000,16'hFF9C,16'h0007,9'h02A, 1'b0, 16'h0000,16'hFEF2,1'b0, 11};
    vecs[3]  = '{MD_IDIV, 1'b0, 16'h0000,16'h0080,16'h0001,9'h100, 1'b1, 16'h0000,16'h0000,1'b0, 11};
    vecs[4]  = '{MD_IDIV, 1'b0, 16'h0000,16'hFF80,16'h0001,9'h001, 1'b1, 16'h0000,16'h0000,1'b0, 11};
    vecs[5]  = '{MD_IMUL, 1'b1, 16'h0000,16'hFFFF,16'h0002,9'h0F0, 1'b0, 16'hFFFF,16'hFFFE,1'b0, 19};
    vecs[6]  = '{MD_MUL,  1'b1, 16'h0000,16'hFFFF,16'h0002,9'h000, 1'b0, 16'h0001,16'hFFFE,1'b1, 19};
    vecs[7]  = '{MD_MUL,  1'b0, 16'h0000,16'h12FF,16'h34FF,9'h0AA, 1'b0, 16'h0000,16'hFE01,1'b1, 11};
    vecs[8]  = '{MD_IMUL, 1'b0, 16'h0000,16'h00FF,16'h0005,9'h155, 1'b0, 16'h0000,16'hFFFB,1'b0, 11};
    vecs[9]  = '{MD_IMUL, 1'b0, 16'h0000,16'h0040,16'h0004,9'h1FF, 1'b0, 16'h0000,16'h0100,1'b1, 11};
    vecs[10] = '{MD_DIV,  1'b1, 16'h0005,16'h0000,16'h0005,9'h033, 1'b1, 16'h0000,16'h0000,1'b0, 2};
    vecs[11] = '{MD_IDIV, 1'b1, 16'hFFFF,16'hFFF9,16'h0002,9'h0CC, 1'b0, 16'hFFFF,16'hFFFD,1'b0, 19};
    vecs[12] = '{MD_DIV,  1'b0, 16'h0000,16'h00FF,16'h0010,9'h111, 1'b0, 16'h0000,16'h0F0F,1'b0, 11};
    vecs[13] = '{MD_IDIV, 1'b1, 16'h0000,16'h8000,16'hFFFF,9'h0AA, 1'b1, 16'h0000,16'h0000,1'b0, 19};
    vecs[14] = '{MD_IDIV, 1'b0, 16'h0000,16'h0064,16'h00F9,9'h055, 1'b0, 16'h0000,16'h02F2,1'b0, 11};
    vecs[15] = '{MD_MUL,  1'b1, 16'h0000,16'h1234,16'h0010,9'h000, 1'b0, 16'h0001,16'h2340,1'b1, 19};
    vecs[16] = '{MD_DIV,  1'b1, 16'h0000,16'h0007,16'h0000,9'h1FF, 1'b1, 16'h0000,16'h0000,1'b0, 2};

    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, divide_error}, 32'd0);
    chk("reset_high", {16'd0, out_high}, 32'd0);
    chk("reset_low", {16'd0, out_low}, 32'd0);
    chk("reset_flags", {23'd0, out_flags}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].op, vecs[i].w, vecs[i].hi, vecs[i].lo, vecs[i].s2, vecs[i].fl, lat, err);
      if (!vecs[i].err) begin
        ef = flags_t'(vecs[i].fl);
        if (vecs[i].op == MD_MUL || vecs[i].op == MD_IMUL) begin
          ef.c = vecs[i].co;
          ef.o = vecs[i].co;
        end
        k_high = vecs[i].eh; k_low = vecs[i].el; k_flags = ef;
      end
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_high", i), {16'd0, out_high}, {16'd0, k_high});
      chk($sformatf("v%0d_low", i), {16'd0, out_low}, {16'd0, k_low});
      chk($sformatf("v%0d_flags", i), {23'd0, out_flags}, {23'd0, k_flags});
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // start pulsed while busy: byte DIV 100/10 must complete unaffected
    opcode = MD_DIV; select_word = 1'b0; source_high = '0; source_low = 16'h0064;
    source_2 = 16'h000A; source_flags = flags_t'(9'h0A5);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    opcode = MD_MUL; source_low = 16'h00FF; source_2 = 16'h0001; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_during_op", {31'd0, busy}, 32'd1);
    cnt = 4;
    while (done !== 1'b1 && cnt < 60) begin @(posedge clock); #1; cnt++; end
    chk("restart_latency", (done === 1'b1) ? cnt + 1 : -1, 11);
    chk("restart_low", {16'd0, out_low}, 32'h0000_000A);
    chk("restart_err", {31'd0, divide_error}, 32'd0);
    k_high = 16'h0000; k_low = 16'h000A; k_flags = flags_t'(9'h0A5);
    cnt = 0;
    repeat (25) begin @(posedge clock); #1; if (done === 1'b1) cnt++; end
    chk("restart_no_second_done", cnt, 0);

    // clear during CALC: idle next cycle, no done, outputs untouched
    opcode = MD_MUL; select_word = 1'b1; source_low = 16'h1234; source_2 = 16'h0010;
    source_flags = '0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    repeat (25) begin @(posedge clock); #1; if (done === 1'b1) cnt++; end
    chk("clear_no_done", cnt, 0);
    chk("clear_high", {16'd0, out_high}, {16'd0, k_high});
    chk("clear_low", {16'd0, out_low}, {16'd0, k_low});
    chk("clear_flags", {23'd0, out_flags}, {23'd0, k_flags});

    // recovery after clear: byte MUL 3*5
    run_op(MD_MUL, 1'b0, 16'h0000, 16'h0003, 16'h0005, 9'h1FF, lat, err);
    chk("post_clear_latency", lat, 11);
    chk("post_clear_low", {16'd0, out_low}, 32'h0000_000F);
    chk("post_clear_flags", {23'd0, out_flags}, {23'd0, 9'h0FE});

    // reset_n low mid-CALC: everything zero immediately
    opcode = MD_DIV; select_word = 1'b1; source_high = 16'h0001; source_low = 16'h0000;
    source_2 = 16'h0003; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, divide_error}, 32'd0);
    chk("rst_high", {16'd0, out_high}, 32'd0);
    chk("rst_low", {16'd0, out_low}, 32'd0);
    chk("rst_flags", {23'd0, out_flags}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
